// File: rtl/fp32_vec_mac_seq.sv
// fp32_vec_mac_seq: time-multiplexed FP32 dot-product engine sharing one multiplier/adder pair.
// Optional macro FP32_VMAC_NAN_FLAG_EN adds a sticky NaN flag output NAN_O.
module fp32_vec_mac_seq #(
  parameter int LANES         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int BEAT_W        = 16
) (
  input  logic                  CLK_I,
  input  logic                  RSTL_I,
  input  logic                  IN_VALID_I,
  output logic                  IN_READY_O,
  input  logic                  IN_LAST_I,
  input  logic [32*LANES-1:0]   ALPHA_I,
  input  logic [32*LANES-1:0]   BRAVO_I,
`ifdef FP32_VMAC_NAN_FLAG_EN
  output logic                  NAN_O,
`endif
  output logic                  OUT_VALID_O,
  input  logic                  OUT_READY_I,
  output logic [31:0]           RESULT_O,
  output logic [BEAT_W-1:0]     BEATS_O
);

  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [LANE_W-1:0]   LANE_LAST   = LANE_W'(LANES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Round-to-nearest-even multiply; subnormal inputs and results flush to signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [47:0]       p;
    logic [22:0]       frac;
    logic              g;
    logic              st;
    logic [23:0]       mr;
    logic signed [9:0] e;
    logic              a_zero;
    logic              b_zero;
    logic [31:0]       r;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    p      = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e      = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
             + $signed({9'd0, p[47]});
    frac   = p[47] ? p[46:24] : p[45:23];
    g      = p[47] ? p[23] : p[22];
    st     = p[47] ? (|p[22:0]) : (|p[21:0]);
    mr     = {1'b0, frac} + {23'd0, g & (st | frac[0])};
    if (mr[23]) begin
      e = e + 10'sd1;
    end else begin
      e = e;
    end
    if (is_nan(a) || is_nan(b) || (is_inf(a) && b_zero) || (is_inf(b) && a_zero)) begin
      r = 32'h7FC0_0000;
    end else if (is_inf(a) || is_inf(b)) begin
      r = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      r = {s, 31'd0};
    end else if (e >= 10'sd255) begin
      r = {s, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      r = {s, 31'd0};
    end else begin
      r = {s, e[7:0], mr[22:0]};
    end
    return r;
  endfunction

  // Round-to-nearest-even add with guard/round/sticky; subnormals flush to zero.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [27:0]       s;
    logic              st;
    logic [23:0]       mr;
    logic signed [9:0] e;
    logic [31:0]       r;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    st = 1'b0;
    if (d >= 8'd27) begin
      my = 27'd1;
    end else begin
      for (int i = 0; i < 27; i++) begin
        st = st | ((i < int'(d)) & my[i]);
      end
      my = (my >> d) | {26'd0, st};
    end
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end else begin
        s = s;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && (s != 28'd0)) begin
          s = s << 1;
          e = e - 10'sd1;
        end else begin
          s = s;
        end
      end
    end
    mr = {1'b0, s[25:3]} + {23'd0, s[2] & (s[1] | s[0] | s[3])};
    if (mr[23]) begin
      e = e + 10'sd1;
    end else begin
      e = e;
    end
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[31] != b[31]))) begin
      r = 32'h7FC0_0000;
    end else if (is_inf(a)) begin
      r = a;
    end else if (is_inf(b)) begin
      r = b;
    end else if ((a[30:23] == 8'd0) && (b[30:23] == 8'd0)) begin
      r = {a[31] & b[31], 31'd0};
    end else if (a[30:23] == 8'd0) begin
      r = b;
    end else if (b[30:23] == 8'd0) begin
      r = a;
    end else if (s == 28'd0) begin
      r = 32'h0000_0000;
    end else if (e >= 10'sd255) begin
      r = {x[31], 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      r = {x[31], 31'd0};
    end else begin
      r = {x[31], e[7:0], mr[22:0]};
    end
    return r;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                state_q;
  logic [32*LANES-1:0]   alpha_q;
  logic [32*LANES-1:0]   bravo_q;
  logic                  last_q;
  logic [LANE_W-1:0]     lane_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic [31:0]           acc_q;
  logic [BEAT_W-1:0]     beats_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [31:0]           op_a_s;
  logic [31:0]           op_b_s;
  logic [31:0]           prod_s;
  logic [31:0]           acc_d;
  logic                  acc_wr_s;
  logic                  out_xfer_s;

  // Select the latched operand pair for the lane currently being settled.
  always_comb begin
    op_a_s = 32'd0;
    op_b_s = 32'd0;
    for (int i = 0; i < LANES; i++) begin
      op_a_s = (int'(lane_q) == i) ? alpha_q[32*i +: 32] : op_a_s;
      op_b_s = (int'(lane_q) == i) ? bravo_q[32*i +: 32] : op_b_s;
    end
  end

  assign prod_s     = fp_mul(op_a_s, op_b_s);
  assign acc_d      = fp_add(prod_s, acc_q);
  assign acc_wr_s   = (state_q == S_CALC) && (settle_q == SETTLE_LAST);
  assign out_xfer_s = (state_q == S_DONE) && OUT_READY_I;

  // Sequencer: IDLE latches a beat, CALC walks lanes, DONE holds the result until taken.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      state_q     <= S_IDLE;
      alpha_q     <= '0;
      bravo_q     <= '0;
      last_q      <= 1'b0;
      lane_q      <= '0;
      settle_q    <= '0;
      acc_q       <= 32'd0;
      beats_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (IN_VALID_I) begin
            alpha_q    <= ALPHA_I;
            bravo_q    <= BRAVO_I;
            last_q     <= IN_LAST_I;
            lane_q     <= '0;
            settle_q   <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          if (acc_wr_s) begin
            acc_q    <= acc_d;
            settle_q <= '0;
            if (lane_q == LANE_LAST) begin
              lane_q <= '0;
              if (beats_q != {BEAT_W{1'b1}}) begin
                beats_q <= beats_q + BEAT_W'(1);
              end
              if (last_q) begin
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= S_IDLE;
              end
            end else begin
              lane_q <= lane_q + LANE_W'(1);
            end
          end else begin
            settle_q <= settle_q + SETTLE_W'(1);
          end
        end
        S_DONE: begin
          if (out_xfer_s) begin
            acc_q       <= 32'd0;
            beats_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP32_VMAC_NAN_FLAG_EN
  logic nan_q;

  // Sticky NaN flag: set on any NaN accumulator write, cleared with the accumulator.
  always_ff @(posedge CLK_I or negedge RSTL_I) begin
    if (!RSTL_I) begin
      nan_q <= 1'b0;
    end else if (out_xfer_s) begin
      nan_q <= 1'b0;
    end else if (acc_wr_s && is_nan(acc_d)) begin
      nan_q <= 1'b1;
    end else begin
      nan_q <= nan_q;
    end
  end

  assign NAN_O = nan_q;
`endif

  assign IN_READY_O  = in_ready_q;
  assign OUT_VALID_O = out_valid_q;
  assign RESULT_O    = acc_q;
  assign BEATS_O     = beats_q;

endmodule

// File: tb/tb_fp32_vec_mac_seq.sv
// Scoreboard bench for fp32_vec_mac_seq: directed dot products with hand-computed FP32 results.
module tb_fp32_vec_mac_seq;
  localparam int LANES  = 4;
  localparam int SETTLE = 2;
  localparam int BEAT_W = 16;

  logic               clk = 1'b0;
  logic               rstl;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [32*LANES-1:0] alpha;
  logic [32*LANES-1:0] bravo;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        result;
  logic [BEAT_W-1:0]  beats;
`ifdef FP32_VMAC_NAN_FLAG_EN
  logic               nan_o;
`endif

  fp32_vec_mac_seq #(.LANES(LANES), .SETTLE_CYCLES(SETTLE), .BEAT_W(BEAT_W)) dut (
    .CLK_I(clk), .RSTL_I(rstl),
    .IN_VALID_I(in_valid), .IN_READY_O(in_ready), .IN_LAST_I(in_last),
    .ALPHA_I(alpha), .BRAVO_I(bravo),
`ifdef FP32_VMAC_NAN_FLAG_EN
    .NAN_O(nan_o),
`endif
    .OUT_VALID_O(out_valid), .OUT_READY_I(out_ready),
    .RESULT_O(result), .BEATS_O(beats)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [15:0] bts;
    logic        nan;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Lane 0 is the rightmost 32 bits of each packed vector.
  localparam logic [127:0] A_ALPHA = {32'hBF800000, 32'h3F000000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] A_BRAVO = {32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3F800000};
  localparam logic [127:0] ONES    = {4{32'h3F800000}};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic expect_res(input logic [31:0] r, input logic [15:0] b, input logic n);
    exp_t e;
    e.res = r;
    e.bts = b;
    e.nan = n;
    sb_q.push_back(e);
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the transfer edge.
  task automatic send_beat(input logic [127:0] a, input logic [127:0] b, input logic last);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) timeout("in_ready_wait");
    in_valid = 1'b1;
    alpha    = a;
    bravo    = b;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) timeout("out_valid_wait");
  endtask

  // Monitor: compare each result on the cycle it is handed over.
  always @(negedge clk) begin
    exp_t e;
    if (rstl && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("beats", 32'(beats), 32'(e.bts));
`ifdef FP32_VMAC_NAN_FLAG_EN
        chk("nan_flag", 32'(nan_o), 32'(e.nan));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int edges;
    rstl      = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    alpha     = '0;
    bravo     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_beats", 32'(beats), 32'd0);
    rstl = 1'b1;
    @(posedge clk); #1;

    // Single beat 2.0 with latency: transfer edge counts as edge 1.
    expect_res(32'h40000000, 16'd1, 1'b0);
    send_beat(A_ALPHA, A_BRAVO, 1'b1);
    edges = 1;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency_edges", 32'(edges), 32'(LANES*SETTLE+1));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(out_valid), 32'd0);

    // Two beats of all-ones -> 8.0.
    expect_res(32'h41000000, 16'd2, 1'b0);
    send_beat(ONES, ONES, 1'b0);
    send_beat(ONES, ONES, 1'b1);
    wait_out_valid();

    // Mixed values: 6 + 2 + 0 + 0 = 8.0.
    expect_res(32'h41000000, 16'd1, 1'b0);
    send_beat({32'h0, 32'h0, 32'h40800000, 32'h40400000},
              {32'h3F800000, 32'h3F800000, 32'h3F000000, 32'h40000000}, 1'b1);
    wait_out_valid();

    // Exact cancellation then 1.5 + 1.5 = 3.0.
    expect_res(32'h40400000, 16'd1, 1'b0);
    send_beat({32'h3FC00000, 32'h3FC00000, 32'hBF800000, 32'h3F800000}, ONES, 1'b1);
    wait_out_valid();

    // Tie rounds to even: 1 + 2^-24 = 1.0, then + 2^-23 = 1 + ulp.
    expect_res(32'h3F800001, 16'd1, 1'b0);
    send_beat({32'h0, 32'h34000000, 32'h33800000, 32'h3F800000}, ONES, 1'b1);
    wait_out_valid();

    // Consumer stalls 10 cycles while the producer pushes garbage.
    @(posedge clk); #1;
    out_ready = 1'b0;
    expect_res(32'h40000000, 16'd1, 1'b0);
    send_beat(A_ALPHA, A_BRAVO, 1'b1);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      alpha    = {$urandom, $urandom, $urandom, $urandom};
      bravo    = {$urandom, $urandom, $urandom, $urandom};
      in_last  = 1'($urandom);
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_result", result, 32'h40000000);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expect_res(32'h40800000, 16'd1, 1'b0);
    send_beat(ONES, ONES, 1'b1);
    wait_out_valid();

    // Reset pulse in the middle of CALC.
    send_beat(A_ALPHA, A_BRAVO, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rstl = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_beats", 32'(beats), 32'd0);
    @(posedge clk); #1;
    rstl = 1'b1;
    @(posedge clk); #1;
    expect_res(32'h40000000, 16'd1, 1'b0);
    send_beat(A_ALPHA, A_BRAVO, 1'b1);
    wait_out_valid();

    // IN_VALID_I toggling with garbage during CALC must not disturb the result.
    expect_res(32'h40000000, 16'd1, 1'b0);
    send_beat(A_ALPHA, A_BRAVO, 1'b1);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      alpha    = {$urandom, $urandom, $urandom, $urandom};
      bravo    = {$urandom, $urandom, $urandom, $urandom};
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out_valid();

`ifdef FP32_VMAC_NAN_FLAG_EN
    expect_res(32'h7FC00000, 16'd1, 1'b1);
    send_beat({A_ALPHA[127:32], 32'h7FC00000}, A_BRAVO, 1'b1);
    wait_out_valid();
    expect_res(32'h40000000, 16'd1, 1'b0);
    send_beat(A_ALPHA, A_BRAVO, 1'b1);
    wait_out_valid();
`endif

    for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
